// File: rtl/mem_load_queue.sv
// In-order load-response queue: tracks outstanding loads, matches returned data,
// extracts/extends load results for writeback and drops data owed across a flush.
module mem_load_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PTR_WD  = 2,
    parameter int unsigned INFO_WD = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [2:0]           req_op,
    input  logic [1:0]           req_addr_low,
    input  logic [INFO_WD-1:0]   req_info,
    output logic                 req_allowin,
    input  logic                 data_sram_dataok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ws_allowin,
    output logic                 out_valid,
    output logic [31:0]          out_result,
    output logic [3:0]           out_rf_we,
    output logic [INFO_WD-1:0]   out_info,
    input  logic                 ws_cancel,
    output logic [PTR_WD:0]      pending_cnt
);

    localparam int unsigned CNT_WD = PTR_WD + 1;
    localparam int unsigned SUM_WD = PTR_WD + 2;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;

    logic [2:0]         op_q    [DEPTH];
    logic [1:0]         alow_q  [DEPTH];
    logic [INFO_WD-1:0] info_q  [DEPTH];
    logic [31:0]        data_q  [DEPTH];
    logic [DEPTH-1:0]   has_data_q;

    logic [PTR_WD-1:0]  head_q, tail_q, resp_q;
    logic [CNT_WD-1:0]  pending_q, await_q, drop_q;

    logic               issue, push, pop, resp_store;
    logic [SUM_WD-1:0]  occupancy, owed, drop_after_cancel;

    // Handshake and bookkeeping decode, all from registered state plus inputs
    always_comb begin
        occupancy   = SUM_WD'(pending_q) + SUM_WD'(drop_q);
        req_allowin = occupancy < SUM_WD'(DEPTH);
        issue       = req_valid && req_allowin;
        push        = issue && !ws_cancel;
        out_valid   = (pending_q != '0) && has_data_q[head_q];
        pop         = out_valid && ws_allowin && !ws_cancel;
        resp_store  = data_sram_dataok && (drop_q == '0) && (await_q != '0) && !ws_cancel;
        owed        = SUM_WD'(drop_q) + SUM_WD'(await_q) + SUM_WD'(issue);
        drop_after_cancel = owed;
        if (data_sram_dataok && owed != '0) begin
            drop_after_cancel = owed - SUM_WD'(1);
        end
    end

    assign pending_cnt = pending_q;

    // Control state: pointers, counters and per-entry data-present flags
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            resp_q     <= '0;
            pending_q  <= '0;
            await_q    <= '0;
            drop_q     <= '0;
            has_data_q <= '0;
        end else if (ws_cancel) begin
            head_q    <= tail_q;
            resp_q    <= tail_q;
            pending_q <= '0;
            await_q   <= '0;
            drop_q    <= CNT_WD'(drop_after_cancel);
        end else begin
            if (push) begin
                has_data_q[tail_q] <= 1'b0;
                tail_q             <= tail_q + PTR_WD'(1);
            end
            if (resp_store) begin
                has_data_q[resp_q] <= 1'b1;
                resp_q             <= resp_q + PTR_WD'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_WD'(1);
            end
            if (data_sram_dataok && drop_q != '0) begin
                drop_q <= drop_q - CNT_WD'(1);
            end
            pending_q <= pending_q + CNT_WD'(push) - CNT_WD'(pop);
            await_q   <= await_q + CNT_WD'(push) - CNT_WD'(resp_store);
        end
    end

    // Entry payload storage; validity is tracked by the control state above
    always_ff @(posedge clk) begin
        if (push) begin
            op_q[tail_q]   <= req_op;
            alow_q[tail_q] <= req_addr_low;
            info_q[tail_q] <= req_info;
        end
        if (resp_store) begin
            data_q[resp_q] <= data_sram_rdata;
        end
    end

    logic [31:0] hd;
    logic [1:0]  ha;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Result extraction for the head entry
    always_comb begin
        hd         = data_q[head_q];
        ha         = alow_q[head_q];
        out_info   = info_q[head_q];
        byte_sel   = 8'(hd >> {ha, 3'b000});
        half_sel   = 16'(hd >> {ha[1], 4'b0000});
        out_result = hd;
        out_rf_we  = 4'b1111;
        case (op_q[head_q])
            OP_LW:   out_result = hd;
            OP_LB:   out_result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  out_result = {24'd0, byte_sel};
            OP_LH:   out_result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  out_result = {16'd0, half_sel};
            OP_LWL: begin
                out_result = hd << {~ha, 3'b000};
                out_rf_we  = 4'b1111 << ~ha;
            end
            OP_LWR: begin
                out_result = hd >> {ha, 3'b000};
                out_rf_we  = 4'b1111 >> ha;
            end
            default: out_result = hd;
        endcase
    end

endmodule

// File: tb/tb_mem_load_queue.sv
// Directed self-checking bench for mem_load_queue.
module tb_mem_load_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [1:0]  req_addr_low;
    logic [63:0] req_info;
    logic        req_allowin;
    logic        data_sram_dataok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_rf_we;
    logic [63:0] out_info;
    logic        ws_cancel;
    logic [2:0]  pending_cnt;

    int checks = 0;
    int errors = 0;

    mem_load_queue #(.DEPTH(4), .PTR_WD(2), .INFO_WD(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr_low(req_addr_low),
        .req_info(req_info), .req_allowin(req_allowin),
        .data_sram_dataok(data_sram_dataok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin), .out_valid(out_valid), .out_result(out_result),
        .out_rf_we(out_rf_we), .out_info(out_info), .ws_cancel(ws_cancel),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 0; req_op = 0; req_addr_low = 0; req_info = 0;
        data_sram_dataok = 0; data_sram_rdata = 0; ws_allowin = 0; ws_cancel = 0;
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (req_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %0b exp 1", req_allowin); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_single_lb();
        req_valid = 1; req_op = 3'd1; req_addr_low = 2'd2; req_info = 64'h0123_4567_89AB_CDEF;
        cycle();
        req_valid = 0;
        checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL lb_pending got %0d exp 1", pending_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lb_early_valid got %0b exp 0", out_valid); end
        data_sram_dataok = 1; data_sram_rdata = 32'h1280_3456;
        cycle();
        data_sram_dataok = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lb_valid got %0b exp 1", out_valid); end
        checks++; if (out_result !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_result got %h exp ffffff80", out_result); end
        checks++; if (out_rf_we !== 4'b1111) begin errors++; $display("FAIL lb_we got %b exp 1111", out_rf_we); end
        checks++; if (out_info !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL lb_info got %h exp 0123456789abcdef", out_info); end
        cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lb_hold got %0b exp 1", out_valid); end
        ws_allowin = 1;
        cycle();
        ws_allowin = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lb_popped got %0b exp 0", out_valid); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL lb_pending_end got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_fill();
        logic [31:0] d [4];
        d[0] = 32'hD000_0000; d[1] = 32'hD111_1111; d[2] = 32'hD222_2222; d[3] = 32'hD333_3333;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_op = 3'd0; req_addr_low = 2'(i); req_info = 64'(i);
            cycle();
        end
        req_valid = 0;
        checks++; if (req_allowin !== 1'b0) begin errors++; $display("FAIL fill_allowin got %0b exp 0", req_allowin); end
        checks++; if (pending_cnt !== 3'd4) begin errors++; $display("FAIL fill_pending got %0d exp 4", pending_cnt); end
        for (int i = 0; i < 4; i++) begin
            data_sram_dataok = 1; data_sram_rdata = d[i];
            cycle();
            checks++; if (out_result !== d[0]) begin errors++; $display("FAIL fill_hold%0d got %h exp %h", i, out_result, d[0]); end
        end
        data_sram_dataok = 0;
        ws_allowin = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_result !== d[i]) begin
                errors++; $display("FAIL fill_pop%0d got v=%0b %h exp v=1 %h", i, out_valid, out_result, d[i]);
            end
            cycle();
            if (i == 0) begin
                checks++; if (req_allowin !== 1'b1) begin errors++; $display("FAIL fill_reopen got %0b exp 1", req_allowin); end
            end
        end
        ws_allowin = 0;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL fill_drain got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_extract();
        logic [2:0]  t_op  [10];
        logic [1:0]  t_a   [10];
        logic [31:0] t_d   [10];
        logic [31:0] t_res [10];
        logic [3:0]  t_we  [10];
        t_op[0]=3'd5; t_a[0]=2'd1; t_d[0]=32'hAABBCCDD; t_res[0]=32'hCCDD0000; t_we[0]=4'b1100;
        t_op[1]=3'd6; t_a[1]=2'd1; t_d[1]=32'hAABBCCDD; t_res[1]=32'h00AABBCC; t_we[1]=4'b0111;
        t_op[2]=3'd4; t_a[2]=2'd3; t_d[2]=32'h80010000; t_res[2]=32'h00008001; t_we[2]=4'b1111;
        t_op[3]=3'd3; t_a[3]=2'd0; t_d[3]=32'h00008000; t_res[3]=32'hFFFF8000; t_we[3]=4'b1111;
        t_op[4]=3'd2; t_a[4]=2'd0; t_d[4]=32'h123456F0; t_res[4]=32'h000000F0; t_we[4]=4'b1111;
        t_op[5]=3'd1; t_a[5]=2'd1; t_d[5]=32'h00007F00; t_res[5]=32'h0000007F; t_we[5]=4'b1111;
        t_op[6]=3'd0; t_a[6]=2'd0; t_d[6]=32'hDEADBEEF; t_res[6]=32'hDEADBEEF; t_we[6]=4'b1111;
        t_op[7]=3'd5; t_a[7]=2'd3; t_d[7]=32'h11223344; t_res[7]=32'h11223344; t_we[7]=4'b1111;
        t_op[8]=3'd6; t_a[8]=2'd3; t_d[8]=32'h11223344; t_res[8]=32'h00000011; t_we[8]=4'b0001;
        t_op[9]=3'd5; t_a[9]=2'd0; t_d[9]=32'h11223344; t_res[9]=32'h44000000; t_we[9]=4'b1000;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1; req_op = t_op[i]; req_addr_low = t_a[i]; req_info = 64'(100 + i);
            cycle();
            req_valid = 0; data_sram_dataok = 1; data_sram_rdata = t_d[i];
            cycle();
            data_sram_dataok = 0;
            checks++; if (out_valid !== 1'b1 || out_result !== t_res[i] || out_rf_we !== t_we[i]) begin
                errors++; $display("FAIL extract%0d got v=%0b %h we=%b exp v=1 %h we=%b", i, out_valid, out_result, out_rf_we, t_res[i], t_we[i]);
            end
            ws_allowin = 1;
            cycle();
            ws_allowin = 0;
        end
    endtask

    task automatic test_cancel();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; req_op = 3'd0; req_addr_low = 0; req_info = 64'(i);
            cycle();
        end
        req_valid = 0; data_sram_dataok = 1; data_sram_rdata = 32'h0BAD_0000;
        cycle();
        data_sram_dataok = 0;
        checks++; if (out_valid !== 1'b1 || pending_cnt !== 3'd3) begin
            errors++; $display("FAIL cancel_setup got v=%0b p=%0d exp v=1 p=3", out_valid, pending_cnt);
        end
        ws_cancel = 1; req_valid = 1; req_info = 64'hDEAD;
        cycle();
        ws_cancel = 0; req_valid = 0;
        checks++; if (pending_cnt !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL cancel_flush got p=%0d v=%0b exp p=0 v=0", pending_cnt, out_valid);
        end
        checks++; if (req_allowin !== 1'b1) begin errors++; $display("FAIL cancel_allowin got %0b exp 1", req_allowin); end
        req_valid = 1; req_op = 3'd0; req_info = 64'hBEEF;
        cycle();
        req_valid = 0;
        checks++; if (req_allowin !== 1'b0 || pending_cnt !== 3'd1) begin
            errors++; $display("FAIL cancel_owed got a=%0b p=%0d exp a=0 p=1", req_allowin, pending_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            data_sram_dataok = 1; data_sram_rdata = 32'h0BAD_0001 + 32'(i);
            cycle();
            checks++; if (out_valid !== 1'b0 || pending_cnt !== 3'd1) begin
                errors++; $display("FAIL cancel_drop%0d got v=%0b p=%0d exp v=0 p=1", i, out_valid, pending_cnt);
            end
            if (i == 0) begin
                checks++; if (req_allowin !== 1'b1) begin errors++; $display("FAIL cancel_drop_allowin got %0b exp 1", req_allowin); end
            end
        end
        data_sram_rdata = 32'hCAFE_F00D;
        cycle();
        data_sram_dataok = 0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hCAFE_F00D || out_info !== 64'hBEEF) begin
            errors++; $display("FAIL cancel_new got v=%0b %h info=%h exp v=1 cafef00d info=beef", out_valid, out_result, out_info);
        end
        ws_allowin = 1;
        cycle();
        ws_allowin = 0;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL cancel_end got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1; req_op = 3'd0; req_addr_low = 0; req_info = 64'd0;
        cycle();
        req_info = 64'd1; data_sram_dataok = 1; data_sram_rdata = 32'h1000_0000;
        cycle();
        ws_allowin = 1;
        for (int i = 0; i < 12; i++) begin
            req_info = 64'(i + 2);
            data_sram_rdata = 32'h1000_0000 + 32'(i + 1) * 32'h0101;
            checks++; if (out_valid !== 1'b1 || out_result !== 32'h1000_0000 + 32'(i) * 32'h0101 || out_info !== 64'(i)) begin
                errors++; $display("FAIL b2b_pop%0d got v=%0b %h info=%0d exp %h", i, out_valid, out_result, out_info, 32'h1000_0000 + 32'(i) * 32'h0101);
            end
            cycle();
            checks++; if (pending_cnt !== 3'd2) begin errors++; $display("FAIL b2b_pending%0d got %0d exp 2", i, pending_cnt); end
        end
        req_valid = 0; data_sram_rdata = 32'h1000_0000 + 32'd13 * 32'h0101;
        checks++; if (out_result !== 32'h1000_0000 + 32'd12 * 32'h0101) begin errors++; $display("FAIL b2b_tail12 got %h", out_result); end
        cycle();
        data_sram_dataok = 0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h1000_0000 + 32'd13 * 32'h0101) begin
            errors++; $display("FAIL b2b_tail13 got v=%0b %h", out_valid, out_result);
        end
        cycle();
        ws_allowin = 0;
        checks++; if (pending_cnt !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got p=%0d v=%0b exp p=0 v=0", pending_cnt, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; req_op = 3'd0; req_info = 64'(i);
            cycle();
        end
        req_valid = 0; reset = 1;
        cycle();
        reset = 0;
        checks++; if (out_valid !== 1'b0 || req_allowin !== 1'b1 || pending_cnt !== 3'd0) begin
            errors++; $display("FAIL rstmid got v=%0b a=%0b p=%0d exp v=0 a=1 p=0", out_valid, req_allowin, pending_cnt);
        end
        req_valid = 1; req_op = 3'd2; req_addr_low = 2'd3; req_info = 64'h77;
        cycle();
        req_valid = 0; data_sram_dataok = 1; data_sram_rdata = 32'hA5_00_00_00;
        cycle();
        data_sram_dataok = 0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_00A5) begin
            errors++; $display("FAIL rstmid_after got v=%0b %h exp v=1 000000a5", out_valid, out_result);
        end
        ws_allowin = 1;
        cycle();
        ws_allowin = 0;
    endtask

    initial begin
        test_reset();
        test_single_lb();
        test_fill();
        test_extract();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
